alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 req_valid  in  1  request present; req_ready  out  1  controller idle, can accept.
REQ-005 req_op  in  3  0 ADD8, 1 SUB8, 2 AND8, 3 OR8, 4 XOR8, 5 ADD16, 6 SUB16, 7 reserved.
REQ-006 req_a, req_b  in  16  operands; 8-bit ops use bits [7:0] only.
REQ-007 alu_a, alu_b  out  8  operands driven to the 8-bit ALU; alu_opcode  out  5  ALU opcode (ADD=0, SUB=1, AND=2, OR=3, XOR=4, INC=12, DEC=13, 31 = unused/zero result).
REQ-008 alu_out  in  8  combinational ALU result for the current alu_a/alu_b/alu_opcode.
REQ-009 rsp_valid  out  1  response present; rsp_ready  in  1  consumer accepts.
REQ-010 rsp_result  out  16, rsp_carry  out  1 (carry/borrow), rsp_zero  out  1, busy  out  1 (state != IDLE).

Function
REQ-011 FSM states IDLE, LO, HI, FIX, RESP; req_ready = (state == IDLE).
REQ-012 IDLE: on req_valid, latch req_op/req_a/req_b and go to LO (accept cycle = cycle 0).
REQ-013 LO: drive alu_a=a[7:0], alu_b=b[7:0], opcode per op (16-bit ops use ADD/SUB); capture alu_out into result[7:0]; low carry = (alu_out < a[7:0]) for ADD, (a[7:0] < b[7:0]) for SUB; 8-bit ops -> RESP, 16-bit ops -> HI.
REQ-014 HI: drive a[15:8], b[15:8], same opcode; capture into result[15:8]; hi carry = (alu_out < a[15:8]) for ADD, (a[15:8] < b[15:8]) for SUB; -> FIX if low carry else RESP.
REQ-015 FIX: alu_a=result[15:8], alu_b=0, opcode INC (ADD16) or DEC (SUB16); capture into result[15:8]; carry |= (old result[15:8] == 0xFF) for INC, (== 0x00) for DEC; -> RESP.
REQ-016 rsp_carry: 8-bit ADD/SUB = low carry; 16-bit = final high carry; AND/OR/XOR/reserved = 0.
REQ-017 rsp_result[15:8] = 0 for 8-bit ops; rsp_zero = (rsp_result == 0).
REQ-018 Reserved op 7: opcode 31 in LO, result 0x0000, carry 0, zero 1, 8-bit latency.
REQ-019 In IDLE/RESP, alu_a=0, alu_b=0, alu_opcode=0.
REQ-020 Latency: rsp_valid first high cycle 2 (8-bit), 3 (16-bit, no low carry), 4 (16-bit with FIX).
REQ-021 RESP: rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready; then IDLE next cycle; next accept no earlier than that IDLE cycle.
REQ-022 req_valid while not IDLE SHALL be ignored; latched operands never change outside IDLE.

Reset
REQ-023 rst_n low at any clock edge, including mid-operation: state IDLE, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, busy=0, req_ready=1, alu outputs 0; in-flight request discarded, no response.

Configuration
REQ-024 Macro ALU_SEQ_OVF_EN defined: output port rsp_overflow (1) present; ADD: sign(a)==sign(b) && sign(res)!=sign(a); SUB: sign(a)!=sign(b) && sign(res)!=sign(a); sign = bit 7 (8-bit) or bit 15 (16-bit); logic/reserved = 0; reset 0, held with response.
REQ-025 Macro undefined: rsp_overflow port and logic absent; all other behaviour identical.

Verification
REQ-026 ADD8 a=0x00F0 b=0x0020 -> rsp_result 0x0010, carry 1, zero 0, rsp_valid at cycle 2, opcode sequence {0}.
REQ-027 ADD16 a=0x00FF b=0x0001 -> opcode sequence {0,0,12}, rsp_result 0x0100, carry 0, zero 0, rsp_valid at cycle 4.
REQ-028 SUB16 a=0x0000 b=0x0001 -> opcode sequence {1,1,13}, rsp_result 0xFFFF, carry 1, zero 0; with ALU_SEQ_OVF_EN overflow 0.
REQ-029 XOR8 a=0x00FF b=0x00FF, rsp_ready low 5 cycles -> rsp_result 0x0000, zero 1, carry 0 held stable; req_ready 0; a req_valid pulse in that window produces no second response.
REQ-030 ADD16 accepted, rst_n low during HI -> next cycle IDLE, req_ready 1, rsp_valid 0 and never asserted for that request.
REQ-031 With ALU_SEQ_OVF_EN: ADD8 a=0x0070 b=0x0010 -> rsp_result 0x0080, overflow 1, carry 0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencer that runs 8/16-bit add/sub/logic requests through an external 8-bit ALU.
// Optional signed-overflow output is enabled by defining ALU_SEQ_OVF_EN.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [7:0]  alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        busy
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic        rsp_overflow
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_RESP} state_t;

    state_t      state, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] result_q, result_d;
    logic        lo_c_q, lo_c_d, carry_q, carry_d, zero_q, zero_d;
    logic        is16, is_add, is_sub, lo_c;
    logic [4:0]  base_opc;

    assign is16   = (op_q == 3'd5) || (op_q == 3'd6);
    assign is_add = (op_q == 3'd0) || (op_q == 3'd5);
    assign is_sub = (op_q == 3'd1) || (op_q == 3'd6);

    always_comb begin
        case (op_q)
            3'd0, 3'd5: base_opc = 5'd0;
            3'd1, 3'd6: base_opc = 5'd1;
            3'd2:       base_opc = 5'd2;
            3'd3:       base_opc = 5'd3;
            3'd4:       base_opc = 5'd4;
            default:    base_opc = 5'd31;
        endcase
    end

    always_comb begin
        state_d    = state;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        lo_c_d     = lo_c_q;
        carry_d    = carry_q;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        lo_c       = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    a_d      = req_a;
                    b_d      = req_b;
                    result_d = '0;
                    lo_c_d   = 1'b0;
                    carry_d  = 1'b0;
                    state_d  = S_LO;
                end
            end
            S_LO: begin
                alu_a      = a_q[7:0];
                alu_b      = b_q[7:0];
                alu_opcode = base_opc;
                result_d[7:0] = (op_q == 3'd7) ? 8'h00 : alu_out;
                if (is_add)
                    lo_c = alu_out < a_q[7:0];
                else if (is_sub)
                    lo_c = a_q[7:0] < b_q[7:0];
                lo_c_d  = lo_c;
                carry_d = is16 ? 1'b0 : lo_c;
                state_d = is16 ? S_HI : S_RESP;
            end
            S_HI: begin
                alu_a      = a_q[15:8];
                alu_b      = b_q[15:8];
                alu_opcode = base_opc;
                result_d[15:8] = alu_out;
                carry_d = is_add ? (alu_out < a_q[15:8]) : (a_q[15:8] < b_q[15:8]);
                state_d = lo_c_q ? S_FIX : S_RESP;
            end
            S_FIX: begin
                // Low-byte carry/borrow is folded into the high byte with INC/DEC.
                alu_a      = result_q[15:8];
                alu_opcode = is_add ? 5'd12 : 5'd13;
                result_d[15:8] = alu_out;
                carry_d = carry_q | (is_add ? (result_q[15:8] == 8'hFF)
                                            : (result_q[15:8] == 8'h00));
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        zero_d = zero_q;
        if (state == S_IDLE && req_valid)
            zero_d = 1'b0;
        else if (state != S_RESP && state_d == S_RESP)
            zero_d = (result_d == 16'h0000);
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_q, ovf_d, sa, sb, sr;
    assign sa = is16 ? a_q[15] : a_q[7];
    assign sb = is16 ? b_q[15] : b_q[7];
    assign sr = is16 ? result_d[15] : result_d[7];

    always_comb begin
        ovf_d = ovf_q;
        if (state == S_IDLE && req_valid)
            ovf_d = 1'b0;
        else if (state != S_RESP && state_d == S_RESP)
            ovf_d = is_add ? ((sa == sb) && (sr != sa)) :
                    is_sub ? ((sa != sb) && (sr != sa)) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign rsp_overflow = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            lo_c_q   <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state    <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            lo_c_q   <= lo_c_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign rsp_valid  = (state == S_RESP);
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;

endmodule
